touch_grid_mapper: RTL and testbench

//  Consumes raw 12-bit touch samples from the touch SPI controller (x_data/y_data + one-cycle new_data strobe).

---
 rtl/touch_ui_pkg.sv | 34 +++
 rtl/touch_grid_mapper_if.sv | 20 ++
 rtl/touch_sample_accumulator.sv | 65 ++++++
 rtl/touch_grid_mapper.sv | 163 ++++++++++++++++
 tb/tb_touch_grid_mapper.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/touch_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module : touch_ui_pkg
// Brief  : Shared FSM states, event kinds and cell-boundary helper.
// Rev    : 1.0 - initial release
// ============================================================================
package touch_ui_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACCUM    = 3'd1,
      S_CLASSIFY = 3'd2,
      S_EMIT     = 3'd3,
      S_LATCHED  = 3'd4
   } state_t;

   localparam logic c_STICKER = 1'b0;
   localparam logic c_COLOUR  = 1'b1;

   localparam int c_DEF_X_MIN       = 240;
   localparam int c_DEF_X_MAX       = 3840;
   localparam int c_DEF_Y_MIN       = 240;
   localparam int c_DEF_Y_MAX       = 3840;
   localparam int c_DEF_X_GRID_END  = 2544;
   localparam int c_DEF_X_PAL_START = 2800;

   // Lower edge of cell k when [lo,hi) is split into equal parts
   function automatic logic [11:0] cell_bound(input int lo, input int hi,
                                              input int parts, input int k);
      return 12'(lo + k * ((hi - lo) / parts));
   endfunction

endpackage
`default_nettype wire

// File: rtl/touch_grid_mapper_if.sv
`default_nettype none
// ============================================================================
// Module : touch_grid_mapper_if
// Brief  : Valid/ready UI event channel from the mapper to the state editor.
// Rev    : 1.0 - initial release
// ============================================================================
interface touch_grid_mapper_if;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_is_colour;
   logic [3:0]  evt_index;
   logic [11:0] evt_x;
   logic [11:0] evt_y;

   modport master (output evt_valid, evt_is_colour, evt_index, evt_x, evt_y,
                   input  evt_ready);
   modport slave  (input  evt_valid, evt_is_colour, evt_index, evt_x, evt_y,
                   output evt_ready);
endinterface
`default_nettype wire

// File: rtl/touch_sample_accumulator.sv
`default_nettype none
// ============================================================================
// Module : touch_sample_accumulator
// Brief  : Per-axis batch sum, min/max span and sample count.
// Rev    : 1.0 - initial release
// ============================================================================
module touch_sample_accumulator #(
   parameter int AVG_LOG2   = 1,
   parameter int JITTER_MAX = 64
) (
   input  logic        clk_1MHz,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [11:0] x_in,
   input  logic [11:0] y_in,
   output logic        batch_done,
   output logic [11:0] avg_x,
   output logic [11:0] avg_y,
   output logic        jitter_bad
);
   localparam int c_N  = 1 << AVG_LOG2;
   localparam int c_SW = 12 + AVG_LOG2;
   localparam int c_CW = AVG_LOG2 + 1;

   logic [c_SW-1:0] r_sum_x, r_sum_y;
   logic [11:0]     r_min_x, r_max_x, r_min_y, r_max_y;
   logic [c_CW-1:0] r_count;

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n || clear) begin
         r_sum_x <= '0;
         r_sum_y <= '0;
         r_min_x <= '0;
         r_max_x <= '0;
         r_min_y <= '0;
         r_max_y <= '0;
         r_count <= '0;
      end else if (accept) begin
         r_sum_x <= r_sum_x + c_SW'(x_in);
         r_sum_y <= r_sum_y + c_SW'(y_in);
         r_count <= r_count + 1'b1;
         // First sample of a batch seeds the span trackers
         if (r_count == '0) begin
            r_min_x <= x_in;
            r_max_x <= x_in;
            r_min_y <= y_in;
            r_max_y <= y_in;
         end else begin
            if (x_in < r_min_x) r_min_x <= x_in;
            if (x_in > r_max_x) r_max_x <= x_in;
            if (y_in < r_min_y) r_min_y <= y_in;
            if (y_in > r_max_y) r_max_y <= y_in;
         end
      end
   end

   assign batch_done = accept && (r_count == c_CW'(c_N - 1));
   assign avg_x      = 12'(r_sum_x >> AVG_LOG2);
   assign avg_y      = 12'(r_sum_y >> AVG_LOG2);
   assign jitter_bad = ((r_max_x - r_min_x) > 12'(JITTER_MAX)) ||
                       ((r_max_y - r_min_y) > 12'(JITTER_MAX));

endmodule
`default_nettype wire

// File: rtl/touch_grid_mapper.sv
`default_nettype none
// ============================================================================
// Module : touch_grid_mapper
// Brief  : Averages touch samples and emits one sticker/colour event per press.
// Rev    : 1.0 - initial release
// ============================================================================
module touch_grid_mapper
   import touch_ui_pkg::*;
#(
   parameter int AVG_LOG2       = 1,
   parameter int JITTER_MAX     = 64,
   parameter int RELEASE_CYCLES = 400000,
   parameter int X_MIN          = c_DEF_X_MIN,
   parameter int X_MAX          = c_DEF_X_MAX,
   parameter int Y_MIN          = c_DEF_Y_MIN,
   parameter int Y_MAX          = c_DEF_Y_MAX,
   parameter int X_GRID_END     = c_DEF_X_GRID_END,
   parameter int X_PAL_START    = c_DEF_X_PAL_START
) (
   input  logic                       clk_1MHz,
   input  logic                       rst_n,
   input  logic [11:0]                x_data,
   input  logic [11:0]                y_data,
   input  logic                       new_data,
   touch_grid_mapper_if.master        evt,
   output logic                       touch_active
);
   localparam int c_TW = $clog2(RELEASE_CYCLES + 1);

   localparam logic [11:0] c_COL_B1 = cell_bound(X_MIN, X_GRID_END, 3, 1);
   localparam logic [11:0] c_COL_B2 = cell_bound(X_MIN, X_GRID_END, 3, 2);
   localparam logic [11:0] c_ROW_B1 = cell_bound(Y_MIN, Y_MAX, 3, 1);
   localparam logic [11:0] c_ROW_B2 = cell_bound(Y_MIN, Y_MAX, 3, 2);
   localparam logic [11:0] c_PAL_B1 = cell_bound(Y_MIN, Y_MAX, 6, 1);
   localparam logic [11:0] c_PAL_B2 = cell_bound(Y_MIN, Y_MAX, 6, 2);
   localparam logic [11:0] c_PAL_B3 = cell_bound(Y_MIN, Y_MAX, 6, 3);
   localparam logic [11:0] c_PAL_B4 = cell_bound(Y_MIN, Y_MAX, 6, 4);
   localparam logic [11:0] c_PAL_B5 = cell_bound(Y_MIN, Y_MAX, 6, 5);

   state_t          r_state, w_state_nxt;
   logic [c_TW-1:0] r_timer;
   logic            w_accept, w_expire, w_acc_accept, w_clear, w_load_evt;
   logic            w_batch_done, w_jitter_bad;
   logic [11:0]     w_avg_x, w_avg_y;
   logic [1:0]      w_col, w_row;
   logic [3:0]      w_sticker, w_colour;
   logic            w_in_grid, w_in_pal;
   logic            r_evt_valid, r_is_colour, r_active;
   logic [3:0]      r_index;
   logic [11:0]     r_x, r_y;

   assign w_accept = new_data &&
                     (x_data >= 12'(X_MIN)) && (x_data <= 12'(X_MAX)) &&
                     (y_data >= 12'(Y_MIN)) && (y_data <= 12'(Y_MAX));
   // A coincident accepted sample always beats expiry
   assign w_expire     = !w_accept && (r_timer == '0) && (r_state != S_IDLE);
   assign w_acc_accept = w_accept && ((r_state == S_IDLE) || (r_state == S_ACCUM));

   touch_sample_accumulator #(
      .AVG_LOG2   (AVG_LOG2),
      .JITTER_MAX (JITTER_MAX)
   ) u_accum (
      .clk_1MHz   (clk_1MHz),
      .rst_n      (rst_n),
      .clear      (w_clear),
      .accept     (w_acc_accept),
      .x_in       (x_data),
      .y_in       (y_data),
      .batch_done (w_batch_done),
      .avg_x      (w_avg_x),
      .avg_y      (w_avg_y),
      .jitter_bad (w_jitter_bad)
   );

   assign w_col     = (w_avg_x >= c_COL_B2) ? 2'd2 : (w_avg_x >= c_COL_B1) ? 2'd1 : 2'd0;
   assign w_row     = (w_avg_y >= c_ROW_B2) ? 2'd2 : (w_avg_y >= c_ROW_B1) ? 2'd1 : 2'd0;
   assign w_sticker = 4'(w_row) * 4'd3 + 4'(w_col);
   // Monotonic bounds: the number of edges crossed is the palette slot
   assign w_colour  = 4'(w_avg_y >= c_PAL_B1) + 4'(w_avg_y >= c_PAL_B2) +
                      4'(w_avg_y >= c_PAL_B3) + 4'(w_avg_y >= c_PAL_B4) +
                      4'(w_avg_y >= c_PAL_B5);
   assign w_in_grid = w_avg_x <  12'(X_GRID_END);
   assign w_in_pal  = w_avg_x >= 12'(X_PAL_START);

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_load_evt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            if (w_batch_done) begin
               w_state_nxt = S_CLASSIFY;
            end else if (w_expire) begin
               w_clear     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_CLASSIFY: begin
            w_clear = 1'b1;
            if (w_jitter_bad) begin
               w_state_nxt = S_ACCUM;
            end else if (w_in_grid || w_in_pal) begin
               w_load_evt  = 1'b1;
               w_state_nxt = S_EMIT;
            end else begin
               w_state_nxt = S_LATCHED;
            end
         end
         S_EMIT: begin
            if (r_evt_valid && evt.evt_ready) w_state_nxt = S_LATCHED;
         end
         S_LATCHED: begin
            if (w_expire) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_timer     <= '0;
         r_active    <= 1'b0;
         r_evt_valid <= 1'b0;
         r_is_colour <= 1'b0;
         r_index     <= '0;
         r_x         <= '0;
         r_y         <= '0;
      end else begin
         if (w_accept)            r_timer <= c_TW'(RELEASE_CYCLES);
         else if (r_timer != '0)  r_timer <= r_timer - 1'b1;
         r_active <= (w_state_nxt != S_IDLE);
         if (w_load_evt) begin
            r_evt_valid <= 1'b1;
            r_is_colour <= w_in_pal ? c_COLOUR : c_STICKER;
            r_index     <= w_in_pal ? w_colour : w_sticker;
            r_x         <= w_avg_x;
            r_y         <= w_avg_y;
         end else if (r_evt_valid && evt.evt_ready) begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign evt.evt_valid     = r_evt_valid;
   assign evt.evt_is_colour = r_is_colour;
   assign evt.evt_index     = r_index;
   assign evt.evt_x         = r_x;
   assign evt.evt_y         = r_y;
   assign touch_active      = r_active;

endmodule
`default_nettype wire

// File: tb/tb_touch_grid_mapper.sv
`default_nettype none
// ============================================================================
// Module : tb_touch_grid_mapper
// Brief  : Directed self-checking bench; release/sample spacing scaled by 1/1000.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_touch_grid_mapper;
   localparam int c_REL = 400;
   localparam int c_GAP = 150;

   logic        clk_1MHz = 1'b0;
   logic        rst_n    = 1'b0;
   logic [11:0] x_data   = '0;
   logic [11:0] y_data   = '0;
   logic        new_data = 1'b0;
   logic        touch_active;
   int          n_chk    = 0;
   int          n_pass   = 0;
   int          evt_count = 0;
   int          n0;

   touch_grid_mapper_if evt_bus ();

   touch_grid_mapper #(.RELEASE_CYCLES(c_REL)) dut (
      .clk_1MHz     (clk_1MHz),
      .rst_n        (rst_n),
      .x_data       (x_data),
      .y_data       (y_data),
      .new_data     (new_data),
      .evt          (evt_bus),
      .touch_active (touch_active)
   );

   always #5 clk_1MHz = ~clk_1MHz;

   always @(posedge clk_1MHz)
      if (rst_n && evt_bus.evt_valid && evt_bus.evt_ready) evt_count <= evt_count + 1;

   task automatic send(input logic [11:0] x, input logic [11:0] y);
      @(negedge clk_1MHz);
      x_data = x; y_data = y; new_data = 1'b1;
      @(negedge clk_1MHz);
      new_data = 1'b0;
   endtask

   // Returns on the negedge of the CLASSIFY cycle
   task automatic press(input logic [11:0] x, input logic [11:0] y);
      send(x, y);
      repeat (c_GAP) @(negedge clk_1MHz);
      send(x, y);
   endtask

   task automatic settle();
      repeat (c_REL + 20) @(negedge clk_1MHz);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; evt_bus.evt_ready = 1'b1;
      repeat (3) @(negedge clk_1MHz);
      n_chk++; if (touch_active !== 1'b0) $display("FAIL rst_active got %b exp 0", touch_active); else n_pass++;
      n_chk++; if (evt_bus.evt_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", evt_bus.evt_valid); else n_pass++;
      n_chk++; if (evt_bus.evt_index !== 4'd0) $display("FAIL rst_index got %0d exp 0", evt_bus.evt_index); else n_pass++;
      n_chk++; if (evt_bus.evt_x !== 12'd0 || evt_bus.evt_y !== 12'd0) $display("FAIL rst_xy got %0d,%0d exp 0,0", evt_bus.evt_x, evt_bus.evt_y); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk_1MHz);
      n_chk++; if (touch_active !== 1'b0) $display("FAIL rst_idle got %b exp 0", touch_active); else n_pass++;
   endtask

   task automatic test_sticker_centre();
      press(12'd1100, 12'd2000);
      n_chk++; if (evt_bus.evt_valid !== 1'b0) $display("FAIL t1_latency got %b exp 0", evt_bus.evt_valid); else n_pass++;
      n_chk++; if (touch_active !== 1'b1) $display("FAIL t1_active got %b exp 1", touch_active); else n_pass++;
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1) $display("FAIL t1_valid got %b exp 1", evt_bus.evt_valid); else n_pass++;
      n_chk++; if (evt_bus.evt_is_colour !== 1'b0) $display("FAIL t1_kind got %b exp 0", evt_bus.evt_is_colour); else n_pass++;
      n_chk++; if (evt_bus.evt_index !== 4'd4) $display("FAIL t1_index got %0d exp 4", evt_bus.evt_index); else n_pass++;
      n_chk++; if (evt_bus.evt_x !== 12'd1100 || evt_bus.evt_y !== 12'd2000) $display("FAIL t1_xy got %0d,%0d exp 1100,2000", evt_bus.evt_x, evt_bus.evt_y); else n_pass++;
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b0) $display("FAIL t1_drop got %b exp 0", evt_bus.evt_valid); else n_pass++;
      settle();
      n_chk++; if (touch_active !== 1'b0) $display("FAIL t1_release got %b exp 0", touch_active); else n_pass++;
   endtask

   task automatic test_palette();
      press(12'd3000, 12'd3700);
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_is_colour !== 1'b1) $display("FAIL pal_top_kind got v%b c%b exp v1 c1", evt_bus.evt_valid, evt_bus.evt_is_colour); else n_pass++;
      n_chk++; if (evt_bus.evt_index !== 4'd5) $display("FAIL pal_top_index got %0d exp 5", evt_bus.evt_index); else n_pass++;
      settle();
      press(12'd3000, 12'd250);
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_is_colour !== 1'b1) $display("FAIL pal_bot_kind got v%b c%b exp v1 c1", evt_bus.evt_valid, evt_bus.evt_is_colour); else n_pass++;
      n_chk++; if (evt_bus.evt_index !== 4'd0) $display("FAIL pal_bot_index got %0d exp 0", evt_bus.evt_index); else n_pass++;
      n_chk++; if (evt_bus.evt_y !== 12'd250) $display("FAIL pal_bot_y got %0d exp 250", evt_bus.evt_y); else n_pass++;
      settle();
   endtask

   task automatic test_jitter();
      n0 = evt_count;
      send(12'd1000, 12'd1000);
      repeat (c_GAP) @(negedge clk_1MHz);
      send(12'd1200, 12'd1000);
      repeat (5) @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 || evt_bus.evt_valid !== 1'b0) $display("FAIL jit_reject got %0d events exp 0", evt_count - n0); else n_pass++;
      n_chk++; if (touch_active !== 1'b1) $display("FAIL jit_active got %b exp 1", touch_active); else n_pass++;
      press(12'd1000, 12'd1000);
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_index !== 4'd0 || evt_bus.evt_is_colour !== 1'b0) $display("FAIL jit_retry got v%b i%0d c%b exp v1 i0 c0", evt_bus.evt_valid, evt_bus.evt_index, evt_bus.evt_is_colour); else n_pass++;
      n_chk++; if (evt_bus.evt_x !== 12'd1000) $display("FAIL jit_retry_x got %0d exp 1000", evt_bus.evt_x); else n_pass++;
      settle();
   endtask

   task automatic test_hold();
      n0 = evt_count;
      for (int i = 0; i < 6; i++) begin
         send(12'd500, 12'd500);
         if (i < 5) repeat (c_GAP) @(negedge clk_1MHz);
      end
      repeat (5) @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 + 1) $display("FAIL hold_once got %0d events exp 1", evt_count - n0); else n_pass++;
      n_chk++; if (touch_active !== 1'b1) $display("FAIL hold_active got %b exp 1", touch_active); else n_pass++;
      repeat (c_REL + 20) @(negedge clk_1MHz);
      n_chk++; if (touch_active !== 1'b0) $display("FAIL hold_release got %b exp 0", touch_active); else n_pass++;
      press(12'd500, 12'd500);
      repeat (3) @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 + 2) $display("FAIL hold_second got %0d events exp 2", evt_count - n0); else n_pass++;
      settle();
   endtask

   task automatic test_backpressure();
      n0 = evt_count;
      evt_bus.evt_ready = 1'b0;
      press(12'd600, 12'd2700);
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_index !== 4'd6) $display("FAIL bp_first got v%b i%0d exp v1 i6", evt_bus.evt_valid, evt_bus.evt_index); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_1MHz);
         n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_index !== 4'd6) $display("FAIL bp_hold%0d got v%b i%0d exp v1 i6", i, evt_bus.evt_valid, evt_bus.evt_index); else n_pass++;
         n_chk++; if (evt_bus.evt_x !== 12'd600 || evt_bus.evt_y !== 12'd2700) $display("FAIL bp_xy%0d got %0d,%0d exp 600,2700", i, evt_bus.evt_x, evt_bus.evt_y); else n_pass++;
      end
      evt_bus.evt_ready = 1'b1;
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b0) $display("FAIL bp_drop got %b exp 0", evt_bus.evt_valid); else n_pass++;
      n_chk++; if (evt_count !== n0 + 1) $display("FAIL bp_count got %0d exp 1", evt_count - n0); else n_pass++;
      settle();
   endtask

   task automatic test_gap_and_invalid();
      n0 = evt_count;
      send(12'd2700, 12'd1000);
      repeat (c_GAP) @(negedge clk_1MHz);
      send(12'd2700, 12'd1000);
      repeat (5) @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 || evt_bus.evt_valid !== 1'b0) $display("FAIL gap_noevt got %0d events exp 0", evt_count - n0); else n_pass++;
      n_chk++; if (touch_active !== 1'b1) $display("FAIL gap_active got %b exp 1", touch_active); else n_pass++;
      repeat (c_REL - 50) @(negedge clk_1MHz);
      send(12'd100, 12'd1000);
      repeat (80) @(negedge clk_1MHz);
      n_chk++; if (touch_active !== 1'b0) $display("FAIL invalid_ignored got %b exp 0", touch_active); else n_pass++;
   endtask

   task automatic test_reset_emit();
      evt_bus.evt_ready = 1'b0;
      press(12'd1100, 12'd2000);
      @(negedge clk_1MHz);
      n0 = evt_count;
      n_chk++; if (evt_bus.evt_valid !== 1'b1) $display("FAIL re_pre got %b exp 1", evt_bus.evt_valid); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (evt_bus.evt_valid !== 1'b0 || touch_active !== 1'b0) $display("FAIL re_async got v%b a%b exp v0 a0", evt_bus.evt_valid, touch_active); else n_pass++;
      n_chk++; if (evt_bus.evt_index !== 4'd0 || evt_bus.evt_x !== 12'd0 || evt_bus.evt_y !== 12'd0) $display("FAIL re_fields got i%0d x%0d y%0d exp 0", evt_bus.evt_index, evt_bus.evt_x, evt_bus.evt_y); else n_pass++;
      @(negedge clk_1MHz);
      rst_n = 1'b1; evt_bus.evt_ready = 1'b1;
      repeat (3) @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 || touch_active !== 1'b0) $display("FAIL re_dropped got %0d events a%b exp 0 a0", evt_count - n0, touch_active); else n_pass++;
      press(12'd1100, 12'd2000);
      @(negedge clk_1MHz);
      n_chk++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_index !== 4'd4 || evt_bus.evt_x !== 12'd1100) $display("FAIL re_fresh got v%b i%0d x%0d exp v1 i4 x1100", evt_bus.evt_valid, evt_bus.evt_index, evt_bus.evt_x); else n_pass++;
      @(negedge clk_1MHz);
      n_chk++; if (evt_count !== n0 + 1) $display("FAIL re_fresh_count got %0d exp 1", evt_count - n0); else n_pass++;
   endtask

   initial begin
      evt_bus.evt_ready = 1'b1;
      test_reset();
      test_sticker_centre();
      test_palette();
      test_jitter();
      test_hold();
      test_backpressure();
      test_gap_and_invalid();
      test_reset_emit();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_chk);
      $fatal(1);
   end

endmodule
`default_nettype wire
